nibble_cpu_core: RTL
====================

# nibble_cpu_core

Parametrised successor to the pin-level 4-bit CPU. It generalises data width and program-counter width, and adds:
- a wait-state memory handshake,
- a real ALU (ADD/SUB/AND/OR/XOR) with Z/C flags,
- conditional branches.

It sits between the TinyTapeout top-level pin mux and external program/data memory; the top level maps its bus onto `uo_out`/`uio_*`.

## Interface
- `DATA_W`, default 4: register/data width; legal values 4 or 8. Data address is 2*`DATA_W` bits.
- `PC_W`, default 8: program counter width; must satisfy `PC_W`+2 >= 2*`DATA_W`.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_addr`  out  `PC_W`+2  fetch: {pc, word index}; data: zero-extended data address
- `mem_instr`  out  1  1 = instruction fetch cycle
- `mem_rd`  out  1  read request (fetch or LOAD)
- `mem_wr`  out  1  write request (STORE)
- `mem_wdata`  out  `DATA_W`  store data; 0 when `mem_wr`=0
- `mem_rdata`  in  `DATA_W`  read data, sampled on the edge where `mem_ready`=1
- `mem_ready`  in  1  completes the current bus cycle
- `halted`  out  1  core stopped (see Configuration)

## Operation
**Instruction fetch and fields**
- Each instruction is three fetched words: W1 = op[3:0] (`mem_rdata[3:0]`), W2 = mode[2:0] (`mem_rdata[2:0]`), W3 = imm[`DATA_W`-1:0].
- Registers: A, X, Y (`DATA_W` each); flags Z, C; PC (`PC_W`). All reset to 0.

**Address modes**
- Data address by mode: 000 {0, imm}; 001 {imm, X}; 010 {Y, imm}; 011 {Y, X}.
- 100 is immediate: operand = imm, no data access.
- 101–111 are reserved: the instruction executes as NOP.

**Opcodes**
- 0 LDA, 1 LDX, 2 LDY: load the operand; Z = (result==0).
- 3 STA, 4 STX, 5 STY: store the register to the data address. Immediate mode makes it a NOP with no bus cycle.
- 6 ADD: A = A+op, C = carry out.
- 7 SUB: A = A−op, C = 1 when A >= op (unsigned).
- 8 AND, 9 OR, A XOR: result to A; Z updated, C unchanged. ADD/SUB also update Z.
- B JMP, C JZ (taken when Z=1), D JC (taken when C=1): on a taken jump, PC = data address zero-extended/truncated to `PC_W`. Immediate mode uses the {0, imm} address form.
- E NOP. F NOP, or HALT when the macro is defined.
- Arithmetic wraps modulo 2^`DATA_W`.

**State machine** (one-hot): FETCH1, FETCH2, FETCH3, LOAD, STORE, JUMP, HALT.
- FETCH1/2/3: `mem_instr`=1, `mem_rd`=1, `mem_addr`={PC, 0/1/2}.
- Exit from FETCH3 (on `mem_ready`):
  - PC increments, wrapping modulo 2^`PC_W`.
  - Next state: STORE for a store; LOAD for a memory-operand load/ALU op; JUMP for a taken jump; HALT for HALT.
  - Otherwise FETCH1. Immediate results, untaken jumps and NOPs write back on this edge.
- LOAD: `mem_rd`=1, `mem_instr`=0. The result writes back on the `mem_ready` edge, then the core goes to FETCH1.
- STORE: `mem_wr`=1, `mem_wdata`=source register; goes to FETCH1 on `mem_ready`.
- JUMP: no bus request, and `mem_ready` is ignored. PC loads the target; the next state is FETCH1.
- HALT: no bus request; the core stays in HALT until reset.

## Timing
- Every bus state (FETCH1/2/3, LOAD, STORE) holds while `mem_ready`=0. During the hold, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata` and `mem_instr` remain stable.
- All outputs are combinational from registered state. None depends on `mem_rdata` or `mem_ready`.
- Minimum cycles with `mem_ready` tied 1:
  - immediate, NOP, or untaken jump: 3
  - load/ALU from memory, or store: 4
  - taken jump: 4
- Each wait cycle adds one cycle.
- Flags and registers written by instruction N are visible to instruction N+1 operand/branch evaluation.
- Reset values:
  - state FETCH1; PC, A, X, Y, Z, C all 0.
  - `mem_addr`=0, `mem_instr`=1, `mem_rd`=1, `mem_wr`=0, `mem_wdata`=0, `halted`=0.
- Reset asserted mid-instruction or mid-wait aborts immediately. No partial writeback occurs.

## Configuration
- `NIBBLE_CPU_HALT_EN` defined:
  - Opcode F enters HALT.
  - `halted`=1 from the cycle after FETCH3 of the HALT instruction; all bus requests are deasserted.
- Undefined: F is NOP, the HALT state is never entered, and `halted` is tied 0.

## Test plan
- Reset, `mem_ready`=1, program LDA imm 5; ADD imm 0xC (`DATA_W`=4) -> A=1, C=1, Z=0 after 6 cycles; PC=2.
- LDX imm 3; STX mode 000 imm 9 -> a STORE cycle with `mem_addr`=0x09, `mem_wdata`=3, `mem_wr`=1 for exactly one cycle.
- Insert 2 wait cycles on FETCH2 and LOAD -> outputs stable during the waits; the instruction completes 4 cycles later than with zero waits.
- SUB to zero, then JZ mode 000 imm 0x10 -> PC=0x10 after the JUMP state. The same test with Z=0 -> PC increments and there is no JUMP state.
- PC=2^`PC_W`−1 executing NOP -> PC wraps to 0. `DATA_W`=8 build: LDA imm 0xFF; ADD imm 1 -> A=0, Z=1, C=1.
- Assert `rst_n` during a LOAD wait, and (with the macro) execute F -> outputs return to reset values; F gives `halted`=1 with no further bus requests.

Source files
------------

// File: rtl/nibble_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nibble_cpu_core : multi-cycle 4/8-bit CPU with wait-state memory bus,    |
// |                   ALU (ADD/SUB/AND/OR/XOR, Z/C) and conditional jumps.   |
// | Option macro    : NIBBLE_CPU_HALT_EN (opcode F halts the core)           |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module nibble_cpu_core #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W+1:0]   mem_addr,
    output logic              mem_instr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted
);

    localparam logic [3:0] c_OP_LDA = 4'h0;
    localparam logic [3:0] c_OP_LDX = 4'h1;
    localparam logic [3:0] c_OP_LDY = 4'h2;
    localparam logic [3:0] c_OP_STA = 4'h3;
    localparam logic [3:0] c_OP_STX = 4'h4;
    localparam logic [3:0] c_OP_STY = 4'h5;
    localparam logic [3:0] c_OP_ADD = 4'h6;
    localparam logic [3:0] c_OP_SUB = 4'h7;
    localparam logic [3:0] c_OP_AND = 4'h8;
    localparam logic [3:0] c_OP_OR  = 4'h9;
    localparam logic [3:0] c_OP_XOR = 4'hA;
    localparam logic [3:0] c_OP_JMP = 4'hB;
    localparam logic [3:0] c_OP_JZ  = 4'hC;
    localparam logic [3:0] c_OP_JC  = 4'hD;
    localparam logic [2:0] c_MODE_IMM = 3'd4;

    typedef enum logic [6:0] {
        S_FETCH1 = 7'b0000001,
        S_FETCH2 = 7'b0000010,
        S_FETCH3 = 7'b0000100,
        S_LOAD   = 7'b0001000,
        S_STORE  = 7'b0010000,
        S_JUMP   = 7'b0100000,
        S_HALT   = 7'b1000000
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic              r_z;
    logic              r_c;
    logic [3:0]        r_op;
    logic [2:0]        r_mode;
    logic [DATA_W-1:0] r_imm;

    logic                r_unused_guard;
    logic                w_mode_ok;
    logic                w_is_imm;
    logic                w_is_ld;
    logic                w_is_alu;
    logic                w_is_st;
    logic                w_is_jmp;
    logic                w_taken;
    logic [2*DATA_W-1:0] w_daddr;
    logic [PC_W+1:0]     w_addr_data;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_res;
    logic                w_c_next;
    logic                w_imm_wb;
    logic                w_wb_en;
    state_t              w_f3_next;

    assign w_mode_ok = (r_mode <= c_MODE_IMM);
    assign w_is_imm  = (r_mode == c_MODE_IMM);
    assign w_is_ld   = (r_op <= c_OP_LDY);
    assign w_is_alu  = (r_op >= c_OP_ADD) && (r_op <= c_OP_XOR);
    assign w_is_st   = (r_op >= c_OP_STA) && (r_op <= c_OP_STY);
    assign w_is_jmp  = (r_op >= c_OP_JMP) && (r_op <= c_OP_JC);
    assign w_taken   = (r_op == c_OP_JMP) || ((r_op == c_OP_JZ) && r_z) ||
                       ((r_op == c_OP_JC) && r_c);

    // Immediate mode shares the {0, imm} address form so jumps can use it directly.
    always_comb begin
        case (r_mode[1:0])
            2'd0:    w_daddr = {{DATA_W{1'b0}}, r_imm};
            2'd1:    w_daddr = {r_imm, r_x};
            2'd2:    w_daddr = {r_y, r_imm};
            default: w_daddr = {r_y, r_x};
        endcase
    end

    assign w_addr_data = (PC_W+2)'(w_daddr);

    // The operand is always the word on the bus: W3 for immediates, the LOAD read otherwise.
    assign w_sum  = {1'b0, r_a} + {1'b0, mem_rdata};
    assign w_diff = {1'b0, r_a} - {1'b0, mem_rdata};

    always_comb begin
        w_res    = mem_rdata;
        w_c_next = r_c;
        case (r_op)
            c_OP_ADD: begin
                w_res    = w_sum[DATA_W-1:0];
                w_c_next = w_sum[DATA_W];
            end
            c_OP_SUB: begin
                w_res    = w_diff[DATA_W-1:0];
                w_c_next = ~w_diff[DATA_W];
            end
            c_OP_AND: w_res = r_a & mem_rdata;
            c_OP_OR:  w_res = r_a | mem_rdata;
            c_OP_XOR: w_res = r_a ^ mem_rdata;
            default:  w_res = mem_rdata;
        endcase
    end

    always_comb begin
        w_f3_next = S_FETCH1;
        w_imm_wb  = 1'b0;
        if (w_mode_ok) begin
            if (w_is_ld || w_is_alu) begin
                if (w_is_imm) begin
                    w_imm_wb = 1'b1;
                end else begin
                    w_f3_next = S_LOAD;
                end
            end else if (w_is_st) begin
                if (!w_is_imm) begin
                    w_f3_next = S_STORE;
                end
            end else if (w_is_jmp) begin
                if (w_taken) begin
                    w_f3_next = S_JUMP;
                end
            end
`ifdef NIBBLE_CPU_HALT_EN
            else if (r_op == 4'hF) begin
                w_f3_next = S_HALT;
            end
`endif
        end
    end

    assign w_wb_en = mem_ready &&
                     (((r_state == S_FETCH3) && w_imm_wb) || (r_state == S_LOAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_FETCH1;
            r_pc           <= '0;
            r_a            <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_z            <= 1'b0;
            r_c            <= 1'b0;
            r_op           <= '0;
            r_mode         <= '0;
            r_imm          <= '0;
            r_unused_guard <= 1'b0;
        end else begin
            r_unused_guard <= 1'b0;
            case (r_state)
                S_FETCH1: begin
                    if (mem_ready) begin
                        r_op    <= mem_rdata[3:0];
                        r_state <= S_FETCH2;
                    end
                end
                S_FETCH2: begin
                    if (mem_ready) begin
                        r_mode  <= mem_rdata[2:0];
                        r_state <= S_FETCH3;
                    end
                end
                S_FETCH3: begin
                    if (mem_ready) begin
                        r_imm   <= mem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= w_f3_next;
                    end
                end
                S_LOAD: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH1;
                    end
                end
                S_STORE: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH1;
                    end
                end
                S_JUMP: begin
                    r_pc    <= PC_W'(w_daddr);
                    r_state <= S_FETCH1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH1;
                end
            endcase

            if (w_wb_en) begin
                case (r_op)
                    c_OP_LDX: r_x <= w_res;
                    c_OP_LDY: r_y <= w_res;
                    default:  r_a <= w_res;
                endcase
                r_z <= (w_res == '0);
                r_c <= w_c_next;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_instr = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            S_FETCH1: begin
                mem_instr = 1'b1;
                mem_rd    = 1'b1;
                mem_addr  = {r_pc, 2'd0};
            end
            S_FETCH2: begin
                mem_instr = 1'b1;
                mem_rd    = 1'b1;
                mem_addr  = {r_pc, 2'd1};
            end
            S_FETCH3: begin
                mem_instr = 1'b1;
                mem_rd    = 1'b1;
                mem_addr  = {r_pc, 2'd2};
            end
            S_LOAD: begin
                mem_rd   = 1'b1;
                mem_addr = w_addr_data;
            end
            S_STORE: begin
                mem_wr   = 1'b1;
                mem_addr = w_addr_data;
                case (r_op)
                    c_OP_STX: mem_wdata = r_x;
                    c_OP_STY: mem_wdata = r_y;
                    default:  mem_wdata = r_a;
                endcase
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

`ifdef NIBBLE_CPU_HALT_EN
    assign halted = (r_state == S_HALT) && !r_unused_guard;
`else
    assign halted = r_unused_guard;
`endif

endmodule
`default_nettype wire
